stepmotor_seq: RTL and testbench

Move sequencer for the 4-coil stepper driver. It accepts one move command at a time (direction, step count, step period) over a valid/ready handshake. It paces the steps with a programmable prescaler and drives the coil pattern directly. It also tracks absolute position and reports busy/done/abort status for the LED and panel logic.

---
 rtl/stepmotor_seq.sv | 191 +++++++++++++++++++
 tb/tb_stepmotor_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stepmotor_seq.sv
// -----------------------------------------------------------------------------
// stepmotor_seq : move sequencer for a 4-coil stepper driver.
//
// Accepts one move command (direction, step count, step period) over a
// valid/ready handshake. Steps are paced by a programmable prescaler. The coil
// pattern, absolute position and busy/done/abort status are all registered.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   cmd_valid  : command present
//   cmd_ready  : high iff the sequencer is idle and can accept a command
//   cmd_dir    : 0 = forward (phase +1), 1 = reverse (phase -1)
//   cmd_steps  : number of steps in the move (0 = empty move, done only)
//   cmd_period : clk cycles per step (0 treated as 1)
//   abort      : terminate the current move (ignored while idle)
//   stepmotor  : registered coil pattern
//   state      : 00 idle, 01 running forward, 10 running reverse
//   done       : one-cycle pulse at the end of every accepted move
//   aborted    : set with done when the move was aborted, cleared on accept
//   position   : absolute step position, two's complement, wraps
//
// Build option:
//   STEPMOTOR_HALF_STEP_EN : when defined, use a 3-bit phase index and the
//                            8-entry half-step table instead of full steps.
// -----------------------------------------------------------------------------
module stepmotor_seq #(
  parameter int CNT_W = 12,
  parameter int DIV_W = 16,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic [3:0]       stepmotor,
  output logic [1:0]       state,
  output logic             done,
  output logic             aborted,
  output logic [POS_W-1:0] position
);

`ifdef STEPMOTOR_HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif

  localparam logic [PH_W-1:0]  PH_ONE  = {{(PH_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fsm_t;

  // Coil pattern for a given phase index.
  function automatic logic [3:0] coil_pattern(input logic [PH_W-1:0] idx);
    logic [3:0] pat;
    case (idx)
`ifdef STEPMOTOR_HALF_STEP_EN
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      3'd7:    pat = 4'b1001;
`else
      2'd0:    pat = 4'b1000;
      2'd1:    pat = 4'b0100;
      2'd2:    pat = 4'b0010;
      2'd3:    pat = 4'b0001;
`endif
      default: pat = 4'b0000;
    endcase
    return pat;
  endfunction

  fsm_t             r_fsm;
  logic             r_dir;
  logic [CNT_W-1:0] r_remain;
  logic [DIV_W-1:0] r_period;
  logic [DIV_W-1:0] r_presc;
  logic [PH_W-1:0]  r_phase;
  logic [3:0]       r_coil;
  logic [1:0]       r_state;
  logic             r_ready;
  logic             r_done;
  logic             r_aborted;
  logic [POS_W-1:0] r_pos;

  logic             w_accept;
  logic             w_wrap;
  logic [DIV_W-1:0] w_period_eff;
  logic [PH_W-1:0]  w_phase_next;

  assign w_accept     = cmd_valid && r_ready;
  // r_period is never 0 (zero is mapped to 1 on accept), so period-1 is safe.
  assign w_wrap       = (r_presc == (r_period - DIV_ONE));
  assign w_period_eff = (cmd_period == {DIV_W{1'b0}}) ? DIV_ONE : cmd_period;
  // Phase index wraps naturally through its own width.
  assign w_phase_next = r_dir ? (r_phase - PH_ONE) : (r_phase + PH_ONE);

  // Sequencer FSM with all status and coil outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm     <= S_IDLE;
      r_dir     <= 1'b0;
      r_remain  <= {CNT_W{1'b0}};
      r_period  <= DIV_ONE;
      r_presc   <= {DIV_W{1'b0}};
      r_phase   <= {PH_W{1'b0}};
      r_coil    <= 4'b0000;
      r_state   <= 2'b00;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_pos     <= {POS_W{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (w_accept) begin
            r_dir     <= cmd_dir;
            r_remain  <= cmd_steps;
            r_period  <= w_period_eff;
            r_presc   <= {DIV_W{1'b0}};
            r_aborted <= 1'b0;
            if (cmd_steps == {CNT_W{1'b0}}) begin
              // Empty move: report completion without ever leaving IDLE.
              r_done <= 1'b1;
            end else begin
              r_fsm   <= S_RUN;
              r_ready <= 1'b0;
              r_state <= cmd_dir ? 2'b10 : 2'b01;
            end
          end else begin
            r_fsm <= S_IDLE;
          end
        end
        S_RUN: begin
          if (abort) begin
            // Abort takes priority over a coincident wrap: no step is taken.
            r_fsm     <= S_IDLE;
            r_ready   <= 1'b1;
            r_state   <= 2'b00;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (w_wrap) begin
            r_presc  <= {DIV_W{1'b0}};
            r_phase  <= w_phase_next;
            r_coil   <= coil_pattern(w_phase_next);
            r_pos    <= r_dir ? (r_pos - POS_ONE) : (r_pos + POS_ONE);
            r_remain <= r_remain - CNT_ONE;
            if (r_remain == CNT_ONE) begin
              r_fsm   <= S_IDLE;
              r_ready <= 1'b1;
              r_state <= 2'b00;
              r_done  <= 1'b1;
            end else begin
              r_fsm <= S_RUN;
            end
          end else begin
            r_presc <= r_presc + DIV_ONE;
          end
        end
        default: begin
          r_fsm   <= S_IDLE;
          r_ready <= 1'b1;
          r_state <= 2'b00;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign stepmotor = r_coil;
  assign state     = r_state;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign position  = r_pos;

endmodule

// File: tb/tb_stepmotor_seq.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for stepmotor_seq.
// -----------------------------------------------------------------------------
module tb_stepmotor_seq;

  localparam int CNT_W = 12;
  localparam int DIV_W = 16;
  localparam int POS_W = 16;
`ifdef STEPMOTOR_HALF_STEP_EN
  localparam int NPH = 8;
`else
  localparam int NPH = 4;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;
  logic             abort;
  logic [3:0]       stepmotor;
  logic [1:0]       state;
  logic             done;
  logic             aborted;
  logic [POS_W-1:0] position;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int dc0;

  stepmotor_seq #(.CNT_W(CNT_W), .DIV_W(DIV_W), .POS_W(POS_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .stepmotor  (stepmotor),
    .state      (state),
    .done       (done),
    .aborted    (aborted),
    .position   (position)
  );

  always #5 clk = ~clk;

  // Count done pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  // Expected coil pattern at phase index idx (idx >= 0).
  function automatic logic [3:0] tab(input int idx);
    logic [3:0] p;
    case (idx % NPH)
`ifdef STEPMOTOR_HALF_STEP_EN
      0: p = 4'b1000;
      1: p = 4'b1100;
      2: p = 4'b0100;
      3: p = 4'b0110;
      4: p = 4'b0010;
      5: p = 4'b0011;
      6: p = 4'b0001;
      7: p = 4'b1001;
`else
      0: p = 4'b1000;
      1: p = 4'b0100;
      2: p = 4'b0010;
      3: p = 4'b0001;
`endif
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command; returns #1 after the accepting edge E0.
  task automatic send(input logic dir, input int steps, input int period);
    cmd_dir    = dir;
    cmd_steps  = CNT_W'(steps);
    cmd_period = DIV_W'(period);
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_coil"},  {28'd0, stepmotor}, 32'h0);
    check({tag, "_state"}, {30'd0, state},     32'h0);
    check({tag, "_ready"}, {31'd0, cmd_ready}, 32'h1);
    check({tag, "_done"},  {31'd0, done},      32'h0);
    check({tag, "_abrt"},  {31'd0, aborted},   32'h0);
    check({tag, "_pos"},   {16'd0, position},  32'h0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0;
    cmd_steps = '0; cmd_period = '0; abort = 1'b0;
    repeat (2) tick();
    check_reset_vals("rst");
    rst = 1'b0;
    tick();

    // 1: forward 4 steps, period 3
    dc0 = done_cnt;
    send(1'b0, 4, 3);
    check("t1_state", {30'd0, state}, 32'h1);
    check("t1_ready", {31'd0, cmd_ready}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      repeat (2) tick();
      if (k == 1) check("t1_nostep", {28'd0, stepmotor}, 32'h0);
      tick();
      check("t1_coil", {28'd0, stepmotor}, {28'd0, tab(k)});
      check("t1_pos", {16'd0, position}, k);
      if (k == 2) check("t1_state_mid", {30'd0, state}, 32'h1);
    end
    check("t1_done", {31'd0, done}, 32'h1);
    check("t1_ready_end", {31'd0, cmd_ready}, 32'h1);
    check("t1_state_end", {30'd0, state}, 32'h0);
    tick();
    check("t1_done_low", {31'd0, done}, 32'h0);
    check("t1_done_cnt", done_cnt - dc0, 32'h1);

    // 2: reverse 2 steps, period 1 (continues from phase index 4)
    send(1'b1, 2, 1);
    check("t2_state", {30'd0, state}, 32'h2);
    tick();
    check("t2_coil1", {28'd0, stepmotor}, {28'd0, tab(3)});
    check("t2_pos1", {16'd0, position}, 32'h3);
    tick();
    check("t2_coil2", {28'd0, stepmotor}, {28'd0, tab(2)});
    check("t2_pos2", {16'd0, position}, 32'h2);
    check("t2_done", {31'd0, done}, 32'h1);
    tick();

    // 3: zero-length move
    check("t3_ready_pre", {31'd0, cmd_ready}, 32'h1);
    send(1'b0, 0, 5);
    check("t3_done", {31'd0, done}, 32'h1);
    check("t3_ready", {31'd0, cmd_ready}, 32'h1);
    check("t3_state", {30'd0, state}, 32'h0);
    check("t3_coil", {28'd0, stepmotor}, {28'd0, tab(2)});
    check("t3_pos", {16'd0, position}, 32'h2);
    tick();
    check("t3_done_low", {31'd0, done}, 32'h0);

    // 4: forward 10 steps, period 4, abort one cycle before the third wrap
    send(1'b0, 10, 4);
    repeat (10) tick();
    check("t4_pos_pre", {16'd0, position}, 32'h4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_done", {31'd0, done}, 32'h1);
    check("t4_abrt", {31'd0, aborted}, 32'h1);
    check("t4_state", {30'd0, state}, 32'h0);
    check("t4_ready", {31'd0, cmd_ready}, 32'h1);
    check("t4_pos", {16'd0, position}, 32'h4);
    check("t4_coil", {28'd0, stepmotor}, {28'd0, tab(4)});
    repeat (2) tick();
    check("t4_pos_hold", {16'd0, position}, 32'h4);
    check("t4_abrt_hold", {31'd0, aborted}, 32'h1);

    // 5: period 0 acts as 1; back-to-back command in the done cycle
    send(1'b0, 3, 0);
    check("t5_abrt_clr", {31'd0, aborted}, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t5_coil", {28'd0, stepmotor}, {28'd0, tab(4 + k)});
      check("t5_pos", {16'd0, position}, 4 + k);
    end
    check("t5_done", {31'd0, done}, 32'h1);
    send(1'b1, 1, 2);
    check("t5_b2b_state", {30'd0, state}, 32'h2);
    check("t5_b2b_ready", {31'd0, cmd_ready}, 32'h0);
    repeat (2) tick();
    check("t5_b2b_pos", {16'd0, position}, 32'h6);
    check("t5_b2b_coil", {28'd0, stepmotor}, {28'd0, tab(6)});
    check("t5_b2b_done", {31'd0, done}, 32'h1);

    // 6: reset, reverse one step from phase 0, then reset mid-move
    rst = 1'b1;
    #1;
    check_reset_vals("t6_rst");
    tick();
    rst = 1'b0;
    tick();
    send(1'b1, 1, 1);
    tick();
    check("t6_pos", {16'd0, position}, 32'hFFFF);
    check("t6_coil", {28'd0, stepmotor}, {28'd0, tab(NPH - 1)});
    tick();
    dc0 = done_cnt;
    send(1'b0, 5, 2);
    repeat (4) tick();
    check("t6_mid_pos", {16'd0, position}, 32'h1);
    check("t6_mid_state", {30'd0, state}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("t6_midrst");
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t6_no_done", done_cnt - dc0, 32'h0);
    check_reset_vals("t6_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
